// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port byte memory between the CPU load/store
// path and the UART debug memory manager. One access per cycle is accepted
// over req/gnt, the winner is registered onto the memory port, and read data
// is steered back to its owner through a latency-matched return pipeline.
// Debug bursts may lock the port; a starvation counter bounds how long a
// waiting CPU can be held off.
module mem_arbiter #(
  parameter int AW        = 19,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  // CPU load/store port
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_ad_i,
  input  logic [DW-1:0] cpu_wd_i,
  output logic          cpu_gnt_o,
  output logic          cpu_stall_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rd_o,
  // debug memory manager port
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_ad_i,
  input  logic [DW-1:0] dbg_wd_i,
  input  logic          dbg_lock_i,
  output logic          dbg_gnt_o,
  output logic          dbg_rvalid_o,
  output logic [DW-1:0] dbg_rd_o,
  // memory macro port
  output logic [AW-1:0] mem_ad_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wd_o,
  input  logic [DW-1:0] mem_rd_i
);

  typedef enum logic [1:0] {
    CPU_LAST   = 2'd0,
    DBG_LAST   = 2'd1,
    DBG_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  state_t        state_q, state_d;
  logic [7:0]    starve_q, starve_d;
  logic          cpu_win, dbg_win;
  logic          any_win;
  logic [AW-1:0] acc_ad;
  logic [DW-1:0] acc_wd;
  logic          acc_we;
  logic          acc_rd;

  logic [AW-1:0] mem_ad_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wd_q;

  // return pipeline: one {valid, owner} entry per latency stage, owner 1 = debug
  logic [RD_LAT-1:0] rv_valid_q;
  logic [RD_LAT-1:0] rv_owner_q;
  logic              tail_valid;
  logic              tail_owner;

  logic          cpu_rvalid_q, dbg_rvalid_q;
  logic [DW-1:0] cpu_rd_q, dbg_rd_q;

  // Arbitration decision, next state and starvation counter update.
  always_comb begin
    cpu_win  = 1'b0;
    dbg_win  = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    if (rst) begin
      case (state_q)
        CPU_LAST: begin
          if (dbg_req_i)      dbg_win = 1'b1;
          else if (cpu_req_i) cpu_win = 1'b1;
        end
        DBG_LAST: begin
          if (cpu_req_i)      cpu_win = 1'b1;
          else if (dbg_req_i) dbg_win = 1'b1;
        end
        DBG_LOCKED: begin
          // a CPU held off for a full burst gets one slot even while locked
          if (cpu_req_i && (starve_q >= MAX_BURST_C)) cpu_win = 1'b1;
          else if (dbg_req_i)                         dbg_win = 1'b1;
          else if (cpu_req_i)                         cpu_win = 1'b1;
        end
        default: ;
      endcase

      if (dbg_win) begin
        state_d = dbg_lock_i ? DBG_LOCKED : DBG_LAST;
      end else if (cpu_win) begin
        if (state_q == DBG_LOCKED) state_d = dbg_lock_i ? DBG_LOCKED : DBG_LAST;
        else                       state_d = CPU_LAST;
      end else if ((state_q == DBG_LOCKED) && !dbg_lock_i) begin
        state_d = DBG_LAST;
      end

      if (cpu_win || !cpu_req_i) begin
        starve_d = '0;
      end else if (dbg_win && (state_q == DBG_LOCKED)) begin
        starve_d = starve_q + 8'd1;
      end
    end
  end

  // Arbiter state and starvation counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= DBG_LAST;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Mux of the winning requester's access fields.
  always_comb begin
    any_win = cpu_win | dbg_win;
    acc_ad  = dbg_win ? dbg_ad_i : cpu_ad_i;
    acc_wd  = dbg_win ? dbg_wd_i : cpu_wd_i;
    acc_we  = dbg_win ? dbg_we_i : cpu_we_i;
    acc_rd  = any_win & ~acc_we;
  end

  // Memory port: an accepted access is presented for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_ad_q <= '0;
      mem_we_q <= 1'b0;
      mem_wd_q <= '0;
    end else if (any_win) begin
      mem_ad_q <= acc_ad;
      mem_we_q <= acc_we;
      mem_wd_q <= acc_wd;
    end else begin
      mem_we_q <= 1'b0;
    end
  end

  // Read return shift register; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rv_valid_q <= '0;
      rv_owner_q <= '0;
    end else begin
      rv_valid_q[0] <= acc_rd;
      rv_owner_q[0] <= dbg_win;
      for (int i = 1; i < RD_LAT; i++) begin
        rv_valid_q[i] <= rv_valid_q[i-1];
        rv_owner_q[i] <= rv_owner_q[i-1];
      end
    end
  end

  assign tail_valid = rv_valid_q[RD_LAT-1];
  assign tail_owner = rv_owner_q[RD_LAT-1];

  // Steer returning memory data to its owner; data holds between pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rd_q     <= '0;
      dbg_rd_q     <= '0;
    end else begin
      cpu_rvalid_q <= tail_valid & ~tail_owner;
      dbg_rvalid_q <= tail_valid & tail_owner;
      if (tail_valid && !tail_owner) cpu_rd_q <= mem_rd_i;
      if (tail_valid && tail_owner)  dbg_rd_q <= mem_rd_i;
    end
  end

  assign cpu_gnt_o    = cpu_win;
  assign cpu_stall_o  = cpu_req_i & ~cpu_win;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign cpu_rd_o     = cpu_rd_q;
  assign dbg_gnt_o    = dbg_win;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_rd_o     = dbg_rd_q;
  assign mem_ad_o     = mem_ad_q;
  assign mem_we_o     = mem_we_q;
  assign mem_wd_o     = mem_wd_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port byte-wide program/data memory between the CPU load/store path and the UART debug memory manager. Accepts one access per cycle from either requester over a req/gnt handshake, registers the winner onto the memory port, and routes read data back with a per-requester valid strobe. Debug bursts can lock the port, bounded by a starvation limit so a stalled CPU always makes progress. Sits between the core, the debug manager and the memory macro.

## Interface
- AW, 19, address width (byte address)
- DW, 8, data width
- RD_LAT, 1, memory read latency in cycles from registered address to valid `mem_rd` (legal 1 or 2)
- MAX_BURST, 16, maximum consecutive locked debug grants while the CPU is waiting (legal 1..255)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_ad  in  AW  CPU address
- cpu_wd  in  DW  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle (combinational)
- cpu_stall  out  1  `cpu_req & ~cpu_gnt`
- cpu_rvalid  out  1  CPU read data valid, one-cycle pulse
- cpu_rd  out  DW  CPU read data, valid with `cpu_rvalid`
- dbg_req, dbg_we, dbg_ad, dbg_wd  in  1/1/AW/DW  debug request, same meaning as CPU
- dbg_lock  in  1  keep the port for the debug side while high
- dbg_gnt, dbg_rvalid, dbg_rd  out  1/1/DW  debug counterparts of CPU outputs
- mem_ad  out  AW  registered memory address
- mem_we  out  1  registered write strobe
- mem_wd  out  DW  registered write data
- mem_rd  in  DW  memory read data

## Operation
- Requester holds req/we/ad/wd stable until it sees gnt; the access is accepted in the cycle where req & gnt. At most one gnt per cycle.
- Arbiter FSM states: CPU_LAST, DBG_LAST, DBG_LOCKED.
  - CPU_LAST: both request -> debug wins; only one requests -> that one wins.
  - DBG_LAST: both request -> CPU wins.
  - Debug grant with `dbg_lock`=1 -> DBG_LOCKED; in DBG_LOCKED, debug wins whenever `dbg_req`=1.
  - DBG_LOCKED exits to DBG_LAST when `dbg_lock`=0 at a cycle with no debug grant or on a debug grant with `dbg_lock`=0.
- Starvation counter: increments on each debug grant in DBG_LOCKED while `cpu_req`=1, clears on any CPU grant or on `cpu_req`=0. At count = MAX_BURST the next cycle with `cpu_req`=1 grants the CPU (even with debug locked) and returns to DBG_LOCKED afterwards if `dbg_lock` is still 1.
- No request: no gnt, `mem_we`=0, state unchanged.
- Accepted access registers ad/we/wd onto the memory port for exactly one cycle; `mem_ad` holds its last value when idle; `mem_we` is 0 on idle cycles.
- Read return: a shift register of depth RD_LAT carries {valid, owner}; at the tail, `mem_rd` is copied to the owner's `*_rd` and its `*_rvalid` pulses. Reads return in issue order; writes produce no rvalid.
- `cpu_rd`/`dbg_rd` hold their last value between pulses.

## Timing
- Reset (rst=0 at a clock edge): state DBG_LAST (CPU wins the first tie), counter 0, `mem_we`=0, `mem_ad`=0, `mem_wd`=0, both rvalid 0, both rd 0, return pipeline cleared. gnt outputs forced 0 while rst=0.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them after reset releases.
- Grant cycle T -> memory port driven in T+1 -> read data at `*_rd` with rvalid in T+1+RD_LAT.
- Back-to-back: one accepted access per cycle sustained; alternating reads from both sides return in interleaved order with no bubble.
- A write at address A followed next cycle by a read of A returns the new data (memory is write-first; arbiter adds no reordering).

## Test plan
- Reset: hold rst=0 2 cycles with both req=1 -> no gnt, mem_we=0, all outputs 0; release -> first cycle grants CPU.
- Solo CPU: write 0xA5 to 0x00010, read 0x00010 -> mem_we pulse at T+1, cpu_rvalid at read-grant+1+RD_LAT with cpu_rd=0xA5, dbg_rvalid never set.
- Contention round-robin: both req continuous, lock=0, 6 cycles -> gnt alternates CPU,DBG,CPU,DBG,CPU,DBG.
- Locked burst with MAX_BURST=4: dbg_lock=1, both req continuous -> 4 debug grants, 1 CPU grant, 4 debug grants; cpu_stall high exactly on non-CPU-grant cycles.
- Interleaved reads, RD_LAT=2: CPU reads 0x100 (0x11), debug reads 0x200 (0x22) consecutively -> cpu_rvalid with 0x11 then dbg_rvalid with 0x22 on the next cycle.
- Reset during read: issue debug read, assert rst=0 the following cycle -> dbg_rvalid never pulses.
